// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - NPCOp encodings, counter constants and saturating counter update
package npc_pkg;

  localparam logic [3:0] NPC_SEQ  = 4'b0000;
  localparam logic [3:0] NPC_BEQ  = 4'b0001;
  localparam logic [3:0] NPC_BNE  = 4'b0010;
  localparam logic [3:0] NPC_BLTZ = 4'b0011;
  localparam logic [3:0] NPC_BLEZ = 4'b0100;
  localparam logic [3:0] NPC_BGTZ = 4'b0101;
  localparam logic [3:0] NPC_BGEZ = 4'b0110;
  localparam logic [3:0] NPC_J    = 4'b0111;
  localparam logic [3:0] NPC_JR   = 4'b1000;

  localparam logic [1:0] CNT_INIT_DEFAULT = 2'b10;
  localparam logic [1:0] CNT_RESET        = 2'b01;
  localparam logic [1:0] CNT_STRONG       = 2'b11;

  function automatic logic [1:0] cnt_sat_update(input logic [1:0] cnt, input logic inc);
    if (inc) begin
      return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    end
    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/npc_btb.sv
// rtl/npc_btb.sv - direct-mapped BTB with 2-bit counters, one lookup and one update port
module npc_btb
  import npc_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [1:0]  CNT_INIT    = CNT_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_jump,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              inv_en
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [BTB_ENTRIES-1:0]             valid_q, valid_d;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [BTB_ENTRIES-1:0][ADDR_W-1:0] target_q, target_d;
  logic [BTB_ENTRIES-1:0][1:0]        cnt_q, cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             unused_pc_lsbs;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle write is not forwarded.
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && cnt_q[lk_idx][1];
  assign lk_target = target_q[lk_idx];
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (upd_en) begin
      if (up_hit) begin
        cnt_d[up_idx]    = cnt_sat_update(cnt_q[up_idx], upd_taken);
        target_d[up_idx] = upd_target;
      end else if (upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        cnt_d[up_idx]    = upd_jump ? CNT_STRONG : CNT_INIT;
      end
    end else if (inv_en && up_hit && cnt_q[up_idx][1]) begin
      // A non-control op hitting a taken entry is an alias; drop it.
      valid_d[up_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      cnt_q    <= {BTB_ENTRIES{CNT_RESET}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/npc_bpred.sv
// rtl/npc_bpred.sv - fetch PC register, BTB prediction and EX-stage branch resolution
module npc_bpred
  import npc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_3000,
  parameter logic [1:0]        CNT_INIT    = CNT_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  output logic [ADDR_W-1:0] if_pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [3:0]        ex_npcop,
  input  logic [ADDR_W-1:0] ex_imm,
  input  logic [ADDR_W-1:0] ex_rs,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic [ADDR_W-1:0] ex_jreg,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              branch_occur,
  output logic              isjump,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispred
);

  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       perf_branches_q, perf_branches_d;
  logic [31:0]       perf_mispred_q, perf_mispred_d;

  logic              btb_taken;
  logic [ADDR_W-1:0] btb_target;
  logic [ADDR_W-1:0] seq, imm_sext, boff, jtgt, res_target, actual_next;
  logic              eq, neg, zero;
  logic              is_cond, is_jump, cond_taken;
  logic              unused_imm_hi;

  assign if_pc          = pc_q;
  assign if_pred_taken  = btb_taken;
  assign if_pred_target = btb_taken ? btb_target : pc_q + ADDR_W'(4);

  assign seq      = ex_pc + ADDR_W'(4);
  assign imm_sext = {{(ADDR_W-16){ex_imm[15]}}, ex_imm[15:0]};
  assign boff     = seq + (imm_sext << 2);
  assign jtgt     = {seq[ADDR_W-1:28], ex_imm[25:0], 2'b00};
  assign eq       = (ex_rs == ex_rt);
  assign neg      = ex_rs[ADDR_W-1];
  assign zero     = (ex_rs == '0);
  assign unused_imm_hi = ^ex_imm[ADDR_W-1:26];

  always_comb begin
    is_cond    = 1'b0;
    is_jump    = 1'b0;
    cond_taken = 1'b0;
    res_target = seq;
    unique case (ex_npcop)
      NPC_BEQ:  begin is_cond = 1'b1; cond_taken = eq;            res_target = boff; end
      NPC_BNE:  begin is_cond = 1'b1; cond_taken = !eq;           res_target = boff; end
      NPC_BLTZ: begin is_cond = 1'b1; cond_taken = neg;           res_target = boff; end
      NPC_BLEZ: begin is_cond = 1'b1; cond_taken = neg || zero;   res_target = boff; end
      NPC_BGTZ: begin is_cond = 1'b1; cond_taken = !neg && !zero; res_target = boff; end
      NPC_BGEZ: begin is_cond = 1'b1; cond_taken = !neg;          res_target = boff; end
      NPC_J:    begin is_jump = 1'b1; res_target = jtgt;    end
      NPC_JR:   begin is_jump = 1'b1; res_target = ex_jreg; end
      default:  ;
    endcase
  end

  assign actual_next  = (cond_taken || is_jump) ? res_target : seq;
  assign redirect     = ex_valid && (actual_next != ex_pred_target);
  assign redirect_pc  = actual_next;
  assign branch_occur = ex_valid && cond_taken;
  assign isjump       = ex_valid && is_jump;

  // jalr targets are register-dependent, so they never train the BTB.
  npc_btb #(
    .ADDR_W      (ADDR_W),
    .BTB_ENTRIES (BTB_ENTRIES),
    .CNT_INIT    (CNT_INIT)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (pc_q),
    .lk_taken   (btb_taken),
    .lk_target  (btb_target),
    .upd_en     (ex_valid && (is_cond || (ex_npcop == NPC_J))),
    .upd_pc     (ex_pc),
    .upd_taken  (cond_taken || is_jump),
    .upd_jump   (ex_npcop == NPC_J),
    .upd_target (res_target),
    .inv_en     (ex_valid && !is_cond && !is_jump)
  );

  always_comb begin
    pc_d            = pc_q;
    perf_branches_d = perf_branches_q;
    perf_mispred_d  = perf_mispred_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (!stall) begin
      pc_d = if_pred_target;
    end
    if (ex_valid && (is_cond || is_jump) && (perf_branches_q != PERF_MAX)) begin
      perf_branches_d = perf_branches_q + 32'd1;
    end
    if (redirect && (perf_mispred_q != PERF_MAX)) begin
      perf_mispred_d = perf_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
    end else begin
      pc_q            <= pc_d;
      perf_branches_q <= perf_branches_d;
      perf_mispred_q  <= perf_mispred_d;
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_mispred  = perf_mispred_q;

endmodule
